// File: rtl/reg_idx_encoder_pkg.sv
// Shared definitions for the register-index encoder: default sizing and the
// output-stage state type.
package enc_pkg;

    localparam int ENC_N_REGS = 32;
    localparam int ENC_IDX_W  = 5;

    // IDLE: no index presented (idx_valid=0); ISSUE: idx holds a valid index
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } enc_state_t;

endpackage

// File: rtl/reg_idx_encoder_prio.sv
// Combinational priority encoder with a rotating start position.
// The search begins at bit 'start' and wraps modulo N; the first set bit
// found in that order is reported on idx, with found flagging a non-empty vec.
module prio_enc32 #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W:0] pos;

    // Walk from the farthest offset back to the nearest so the nearest set bit wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, start} + (W+1)'(i);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            if (vec[pos[W-1:0]]) begin
                idx   = pos[W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_idx_encoder.sv
// Register write-request index encoder.
// Collects multi-hot write requests into a pending set and issues one encoded
// register index per cycle through a valid/ready output register.
// Handshake: idx/idx_valid change only when idx_valid=0 or on an edge with
// idx_valid=1 and idx_ready=1 (transfer); while stalled they hold stable.
// Optional feature: define ENC_ROUND_ROBIN_EN to rotate selection priority
// starting just after the last issued index; otherwise lowest index wins.
module reg_idx_encoder
    import enc_pkg::*;
#(
    parameter int N_REGS        = ENC_N_REGS,
    parameter int IDX_W         = ENC_IDX_W,
    parameter int ZERO_REG_MASK = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_en,
    input  logic [N_REGS-1:0] req_vec,
    input  logic              flush,
    output logic              idx_valid,
    output logic [IDX_W-1:0]  idx,
    input  logic              idx_ready,
    output logic [IDX_W:0]    pending_cnt
);

    // Top bit is the hard-wired zero register when masking is enabled
    localparam logic [N_REGS-1:0] REQ_MASK = (ZERO_REG_MASK != 0) ?
        {1'b0, {(N_REGS-1){1'b1}}} : {N_REGS{1'b1}};

    enc_state_t        state;
    logic [N_REGS-1:0] pending;
    logic [N_REGS-1:0] pending_nxt;
    logic [N_REGS-1:0] clr_vec;
    logic [N_REGS-1:0] set_vec;
    logic              transfer;
    logic              load;
    logic              valid_nxt;
    logic              found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W:0]    cnt_nxt;

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Search starts one past the last issued index, wrapping at N_REGS
    always_comb begin
        start_idx = '0;
        if (rr_ptr != IDX_W'(N_REGS - 1)) begin
            start_idx = rr_ptr + IDX_W'(1);
        end
    end

    // Remember the index taken by each output load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= IDX_W'(N_REGS - 1);
        end else if (load && !flush) begin
            rr_ptr <= sel_idx;
        end
    end
`else
    assign start_idx = '0;
`endif

    prio_enc32 #(
        .N (N_REGS),
        .W (IDX_W)
    ) u_prio (
        .vec   (pending),
        .start (start_idx),
        .idx   (sel_idx),
        .found (found)
    );

    // Next pending set: clear the bit being loaded, then merge new requests (set wins)
    always_comb begin
        transfer  = idx_valid && idx_ready;
        load      = (!idx_valid || transfer) && found;
        valid_nxt = load || (idx_valid && !transfer);
        clr_vec   = '0;
        if (load) begin
            clr_vec[sel_idx] = 1'b1;
        end
        set_vec     = req_en ? (req_vec & REQ_MASK) : '0;
        pending_nxt = (pending & ~clr_vec) | set_vec;
        cnt_nxt     = (IDX_W+1)'(valid_nxt);
        for (int i = 0; i < N_REGS; i++) begin
            cnt_nxt = cnt_nxt + (IDX_W+1)'(pending_nxt[i]);
        end
    end

    // Output-stage FSM; idx and idx_valid are registered outputs of this block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
            idx       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            idx_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= ISSUE;
                        idx_valid <= 1'b1;
                        idx       <= sel_idx;
                    end
                end
                ISSUE: begin
                    if (transfer) begin
                        if (found) begin
                            idx <= sel_idx;
                        end else begin
                            state     <= IDLE;
                            idx_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Pending set and its registered count (pending bits plus the presented index)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else if (flush) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: doc/reg_idx_encoder.md
REG_IDX_ENCODER -- requirements
Module: reg_idx_encoder

Interface
REQ-001 Parameter N_REGS, default 32, number of register write-request lines.
REQ-002 Parameter IDX_W, default 5, encoded index width (log2 N_REGS).
REQ-003 Parameter ZERO_REG_MASK, default 1; when 1, request bit N_REGS-1 (zero register) is ignored.
REQ-004 Ports, in order. One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req_en  input  1  req_vec sampled this edge when high.
REQ-008 req_vec  input  N_REGS  multi-hot write-request vector, bit i = register i.
REQ-009 flush  input  1  synchronous clear of all pending work.
REQ-010 idx_valid  output  1  idx holds a valid encoded register index.
REQ-011 idx  output  IDX_W  encoded register index.
REQ-012 idx_ready  input  1  consumer accepts idx this edge.
REQ-013 pending_cnt  output  IDX_W+1  count of outstanding requests, including the one presented.

Function
REQ-014 Internal pending[N_REGS-1:0]; on an edge with req_en=1, pending |= req_vec (masked per REQ-003).
REQ-015 Transfer occurs on an edge where idx_valid=1 and idx_ready=1.
REQ-016 Output register loads when idx_valid=0 or a transfer occurs, and a pending bit exists; the selected bit is cleared from pending on that load.
REQ-017 Same-edge set and clear of the same pending bit: set wins; the index is reissued later.
REQ-018 While idx_valid=1 and idx_ready=0, idx and idx_valid hold stable.
REQ-019 Latency: request sampled at edge E0 gives idx_valid=1 after edge E1, with an idle output register.
REQ-020 Throughput: one index per cycle under continuous idx_ready=1.
REQ-021 FSM IDLE (idx_valid=0), ISSUE (idx_valid=1); IDLE->ISSUE when pending!=0; ISSUE->IDLE on transfer with pending==0 after merge; otherwise stay in ISSUE.
REQ-022 Default selection: lowest-numbered pending bit wins.
REQ-023 pending_cnt = popcount(pending) + idx_valid, registered view; max value N_REGS, no overflow.
REQ-024 flush=1: pending, idx_valid, and pending_cnt cleared after the edge; req_vec sampled on that edge is discarded (flush wins); an in-flight transfer is dropped.
REQ-025 req_vec bit N_REGS-1 with ZERO_REG_MASK=1 never sets pending and never appears on idx.

Reset
REQ-026 reset_n low asynchronously clears pending, sets FSM=IDLE, idx_valid=0, idx=0, pending_cnt=0, and the round-robin pointer to N_REGS-1.
REQ-027 Reset asserted mid-drain discards all outstanding requests; no index is issued after release until new requests arrive.
REQ-028 Outputs are driven from flops only; no combinational path from inputs to outputs.

Configuration
REQ-029 Macro ENC_ROUND_ROBIN_EN: when defined, selection starts at last-issued index+1 and wraps modulo N_REGS; the pointer updates on each output load.
REQ-030 Without ENC_ROUND_ROBIN_EN, fixed lowest-index priority per REQ-022 applies and no pointer flops exist.

Structure
REQ-031 Package enc_pkg holds N_REGS, IDX_W defaults and enum enc_state_t {IDLE, ISSUE}.
REQ-032 Sub-module prio_enc32: combinational N_REGS-to-IDX_W priority encoder with start-pointer input and found flag, used for selection.

Verification
REQ-033 req_vec=0x0000_0015, req_en one cycle, idx_ready=1 -> idx 0,2,4 on consecutive cycles; idx_valid first high 2 cycles after request; pending_cnt 3,2,1,0.
REQ-034 req_vec=0x8000_0001 with ZERO_REG_MASK=1 -> only idx=0 issued; pending_cnt peaks at 1.
REQ-035 idx_ready=0 for 5 cycles with idx=3 presented -> idx=3 and idx_valid stable; new req bit 3 during stall -> idx=3 issued twice total.
REQ-036 With ENC_ROUND_ROBIN_EN: issue idx=5, then req_vec=0x0000_0041 -> idx=6 before idx=0; without the macro -> idx=0 first.
REQ-037 Pending 0x0000_00FF, flush=1 with req_vec=0x100 same edge -> idx_valid=0, pending_cnt=0; nothing issued afterward.
REQ-038 reset_n pulsed low asynchronously mid-drain -> outputs 0 immediately; no issue after release without new requests.
